// File: rtl/pipeline_ctrl_defs.sv
// Shared definitions for the pipeline stall controller.
// States, NOP encoding and MDU timeout default.
package pipeline_ctrl_defs;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int MDU_TIMEOUT_DEF = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush/bubble control for the 5-stage RV32IM pipeline.
// Handles load-use, EX redirects and the MDU start/done handshake.
module pipeline_stall_controller
  import pipeline_ctrl_defs::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             branch_taken_ex,
  input  logic             mdu_op_ex,
  input  logic             mdu_done,
  output logic             mdu_start,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_stage_hold,
  output logic             ex_ma_bubble,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW =
    (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(MDU_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          tmo_q, tmo_d;
  logic          waiting;
  logic          wait_last;
  logic          release_c;

  assign waiting   = (state_q == MDU_WAIT);
  assign wait_last = (wait_q == WAIT_LAST);
  assign release_c = waiting &&
                     (mdu_done || wait_last);

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    tmo_d          = tmo_q;
    mdu_start      = 1'b0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_stage_hold  = 1'b0;
    ex_ma_bubble   = 1'b0;
    if (reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      ex_ma_bubble   = 1'b1;
    end else if (waiting && !release_c) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      ex_stage_hold  = 1'b1;
      ex_ma_bubble   = 1'b1;
      wait_d         = wait_q + 1'b1;
    end else begin
      // Release cycle: the op in EX is the one finishing.
      if (release_c) begin
        state_d = RUN;
        if (!mdu_done) tmo_d = 1'b1;
      end
      if (branch_taken_ex) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (!waiting && mdu_op_ex) begin
        mdu_start      = 1'b1;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        ex_stage_hold  = 1'b1;
        ex_ma_bubble   = 1'b1;
        state_d        = MDU_WAIT;
        wait_d         = '0;
      end else if (load_use_stall) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mdu_timeout = tmo_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_write_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized and directed bench for pipeline_stall_controller.
// Expected behaviour comes from a rule-level model in the bench.
module tb_pipeline_stall_controller;

  localparam int TO  = 8;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_use_stall;
  logic          branch_taken_ex;
  logic          mdu_op_ex;
  logic          mdu_done;
  logic          mdu_start;
  logic          pc_write_en;
  logic          if_id_write_en;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          ex_stage_hold;
  logic          ex_ma_bubble;
  logic          mdu_timeout;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_count;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_busy;
  int m_cycles;
  int m_stall;
  int m_flush;
  bit m_tmo;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MDU_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_stall  (load_use_stall),
    .branch_taken_ex (branch_taken_ex),
    .mdu_op_ex       (mdu_op_ex),
    .mdu_done        (mdu_done),
    .mdu_start       (mdu_start),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_stage_hold   (ex_stage_hold),
    .ex_ma_bubble    (ex_ma_bubble),
    .mdu_timeout     (mdu_timeout),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // One cycle: drive, compare against the model, advance.
  // Vector order: start pc ifid flush bubble hold exma
  task automatic step(bit rst, bit lu, bit br,
                      bit op, bit dn);
    bit [6:0] e;
    bit       rel;
    bit       tmo_now;
    @(negedge clk);
    reset           = rst;
    load_use_stall  = lu;
    branch_taken_ex = br;
    mdu_op_ex       = op;
    mdu_done        = dn;
    #1;
    tmo_now = m_busy && !dn && (m_cycles == TO - 1);
    rel     = m_busy && (dn || tmo_now);
    if (rst)
      e = 7'b0_00_11_01;
    else if (m_busy && !rel)
      e = 7'b0_00_00_11;
    else if (br)
      e = 7'b0_11_11_00;
    else if (!m_busy && op)
      e = 7'b1_00_00_11;
    else if (lu)
      e = 7'b0_00_01_00;
    else
      e = 7'b0_11_00_00;
    check("ctrl",
          {mdu_start, pc_write_en, if_id_write_en,
           if_id_flush, id_ex_bubble, ex_stage_hold,
           ex_ma_bubble}, 32'(e));
    check("stall_cycles", 32'(stall_cycles), m_stall);
    check("flush_count", 32'(flush_count), m_flush);
    check("mdu_timeout", 32'(mdu_timeout), 32'(m_tmo));
    if (rst) begin
      m_busy = 0; m_cycles = 0; m_tmo = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e[5]) m_stall = (m_stall < MAX) ? m_stall + 1 : MAX;
      if (e[3])  m_flush = (m_flush < MAX) ? m_flush + 1 : MAX;
      if (tmo_now) m_tmo = 1;
      if (e[6]) begin
        m_busy = 1; m_cycles = 0;
      end else if (rel) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_cycles++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; load_use_stall = 0; branch_taken_ex = 0;
    mdu_op_ex = 0; mdu_done = 0;
    m_busy = 0; m_cycles = 0; m_stall = 0;
    m_flush = 0; m_tmo = 0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("rst_stall", 32'(stall_cycles), 0);
    check("rst_flush", 32'(flush_count), 0);
    check("rst_tmo", 32'(mdu_timeout), 0);

    // single load-use cycle
    step(0, 1, 0, 0, 0);
    check("lu_stall", 32'(stall_cycles), 1);

    // branch beats load-use
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("br_flush", 32'(flush_count), 1);
    check("br_stall", 32'(stall_cycles), 0);

    // MDU handshake: done five cycles after start
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    check("mdu_stall", 32'(stall_cycles), 5);
    step(0, 0, 0, 0, 0);
    check("mdu_after", 32'(stall_cycles), 5);

    // back-to-back op right after a release
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    idle(1);

    // timeout with no done
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 1, 0);
    check("tmo_set", 32'(mdu_timeout), 1);
    idle(3);
    check("tmo_sticky", 32'(mdu_timeout), 1);

    // reset on the third wait cycle aborts
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    idle(2);
    check("abort_tmo", 32'(mdu_timeout), 0);

    // counter saturation
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    check("sat_stall", 32'(stall_cycles), MAX);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
    check("sat_flush", 32'(flush_count), MAX);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Consumes hazard and resolution requests from the ID/EX stages and drives the pipeline-register write enables, flushes and bubbles for the RV32IM five-stage pipeline. It is the receiving end of the load-use stall request, the EX-stage branch redirect, and the start/done handshake with the multi-cycle multiply/divide unit (MDU). It also keeps saturating stall and flush performance counters. It sits between the hazard detection logic and the IF/ID, ID/EX and EX/MA register banks.

## Interface
- MDU_TIMEOUT, 64: maximum number of cycles spent in MDU_WAIT before a forced release.
- CNT_W, 32: width of the performance counters.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_use_stall  in  1  load-use hazard request from hazard detection (EX holds a load, ID consumes its rd)
- branch_taken_ex  in  1  branch/jump in EX resolved taken this cycle
- mdu_op_ex  in  1  EX holds a valid MUL/DIV/REM instruction
- mdu_done  in  1  one-cycle pulse from the MDU; result is valid this cycle
- mdu_start  out  1  one-cycle issue pulse to the MDU
- pc_write_en  out  1  PC register load enable
- if_id_write_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP
- ex_stage_hold  out  1  hold the ID/EX register and EX operands
- ex_ma_bubble  out  1  EX/MA loads a NOP
- mdu_timeout  out  1  sticky error flag; set on a forced MDU release
- stall_cycles  out  CNT_W  count of cycles with pc_write_en=0
- flush_count  out  CNT_W  count of cycles with if_id_flush=1

## Operation
- FSM states: RUN, MDU_WAIT. Reset state is RUN.
- Default outputs: pc_write_en=1, if_id_write_en=1, all other controls 0.
- Rules in RUN, in priority order:
  1. branch_taken_ex: if_id_flush=1, id_ex_bubble=1, pc_write_en=1. load_use_stall is ignored. mdu_op_ex together with branch_taken_ex is illegal; branch wins and no mdu_start is issued.
  2. mdu_op_ex: mdu_start=1, pc_write_en=0, if_id_write_en=0, ex_stage_hold=1, ex_ma_bubble=1. Next state is MDU_WAIT.
  3. load_use_stall: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
- MDU_WAIT, no mdu_done: same hold pattern as rule 2, with mdu_start=0. Wait counter increments.
- MDU_WAIT, mdu_done: release cycle.
  - ex_stage_hold=0, ex_ma_bubble=0; the MDU result advances to EX/MA.
  - mdu_op_ex is ignored this cycle (same op), so there is no re-issue.
  - Rules 1 and 3 are evaluated normally.
  - Next state is RUN.
- Timeout: the wait counter is cleared on entry to MDU_WAIT. When the counter equals MDU_TIMEOUT-1 and mdu_done=0, the controller behaves as a release cycle, sets mdu_timeout at the next edge and returns to RUN.
- mdu_done while in RUN is ignored.
- mdu_timeout stays set until reset.
- Counters saturate at all-ones and never wrap. Both counters may increment in the same cycle.

## Timing
- While reset=1: pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1, ex_ma_bubble=1, mdu_start=0, ex_stage_hold=0. On the reset edge: state=RUN, wait counter=0, mdu_timeout=0, both counters=0.
- All control outputs are combinational from the state and the current inputs, so the effect is at the same edge. Only state, counters and mdu_timeout are registered.
- mdu_start is asserted in the first cycle an MDU op is in EX.
- mdu_done is legal from the cycle after mdu_start onward. Minimum MDU occupancy is 2 cycles: the issue cycle plus the done cycle.
- A back-to-back MDU op arriving in EX the cycle after a release is issued normally from RUN.
- Reset asserted during MDU_WAIT aborts the wait. The MDU is reset by the same signal.
- stall_cycles includes the issue cycle, every wait cycle and every load-use cycle.

## Structure
- Shared package/header pipeline_ctrl_defs holds:
  - state encodings (RUN=1'b0, MDU_WAIT=1'b1)
  - the NOP instruction constant used by the flush/bubble consumers
  - the default MDU_TIMEOUT
- Sub-module sat_counter (parameter W, ports clk/reset/inc/count), instantiated twice for the performance counters.

## Test plan
- Reset: hold reset 3 cycles -> flush/bubbles=1, enables=0. After release, stall_cycles=0, flush_count=0, mdu_timeout=0.
- Load-use: load_use_stall=1 for 1 cycle -> pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 that cycle; stall_cycles=1.
- Branch priority: branch_taken_ex=1 and load_use_stall=1 together -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1; flush_count=1, stall_cycles=0.
- MDU handshake: mdu_op_ex held high, mdu_done pulsed 5 cycles after mdu_start -> exactly one mdu_start pulse, 6 cycles with ex_stage_hold=0 only on the done cycle, stall_cycles=5, no re-issue on the done cycle.
- Timeout: MDU_TIMEOUT=8, mdu_done never asserted -> release on the 8th MDU_WAIT cycle, mdu_timeout=1 from the next cycle and sticky, state RUN.
- Reset mid-wait plus saturation: assert reset on the 3rd MDU_WAIT cycle -> next state RUN, no release pulse. With CNT_W=4, run 20 load-use cycles -> stall_cycles=15.
